// File: rtl/ami_port_mem_tester_pkg.sv
// rtl/ami_port_mem_tester_pkg.sv - AMI request/response types, tester states and line pattern
package ami_port_mem_tester_pkg;

  localparam int AMI_LINE_BYTES = 64;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    WAIT  = 3'd3,
    DONE  = 3'd4
  } tester_state_e;

  typedef struct packed {
    logic         valid;
    logic         isWrite;
    logic [63:0]  addr;
    logic [511:0] data;
  } MemReq;

  typedef struct packed {
    logic         valid;
    logic [511:0] data;
  } MemResp;

  // Line idx carries the 32-bit word (seed + idx) replicated across all 64 bytes.
  function automatic logic [511:0] ami_tester_pattern(input logic [31:0] seed,
                                                      input logic [15:0] idx);
    logic [31:0] word;
    word = seed + {16'd0, idx};
    return {16{word}};
  endfunction

endpackage

// File: rtl/ami_port_mem_tester.sv
// rtl/ami_port_mem_tester.sv - write/read-back memory self-test engine for one AMI port
module ami_port_mem_tester
  import ami_port_mem_tester_pkg::*;
#(
  parameter int unsigned NUM_LINES       = 8,
  parameter logic [63:0] BASE_ADDR       = 64'd0,
  parameter logic [63:0] STRIDE          = 64'd64,
  parameter logic [31:0] PATTERN_BASE    = 32'hDEAD0000,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output MemReq       mem_req_out,
  input  logic        mem_req_grant_in,
  input  MemResp      mem_resp_in,
  output logic        mem_resp_grant_out,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic [15:0] err_count,
  output logic [15:0] first_err_idx
);

  localparam logic [15:0] LAST_IDX  = 16'(NUM_LINES - 1);
  localparam logic [3:0]  MAX_OUT   = 4'(MAX_OUTSTANDING);
  localparam logic [31:0] WDOG_LAST = 32'(TIMEOUT_CYCLES - 1);

  tester_state_e state_q, state_d;
  logic [15:0]   idx_q, idx_d;
  logic [15:0]   resp_idx_q, resp_idx_d;
  logic [3:0]    outstanding_q, outstanding_d;
  logic [31:0]   wdog_q, wdog_d;
  logic          done_q, done_d;
  logic          pass_q, pass_d;
  logic          timeout_q, timeout_d;
  logic [15:0]   err_q, err_d;
  logic [15:0]   first_q, first_d;

  logic req_valid, req_fire, resp_fire, resp_bad, activity, run_active, wdog_expired;

  always_comb begin
    req_valid = (state_q == WRITE) || ((state_q == READ) && (outstanding_q != MAX_OUT));
    mem_req_out.valid   = req_valid;
    mem_req_out.isWrite = (state_q == WRITE);
    mem_req_out.addr    = BASE_ADDR + 64'(idx_q) * STRIDE;
    mem_req_out.data    = (state_q == WRITE) ? ami_tester_pattern(PATTERN_BASE, idx_q) : '0;
    mem_resp_grant_out  = mem_resp_in.valid && ((state_q == READ) || (state_q == WAIT)) &&
                          (outstanding_q != 4'd0);
  end

  assign req_fire     = req_valid && mem_req_grant_in;
  assign resp_fire    = mem_resp_grant_out;
  assign resp_bad     = mem_resp_in.data != ami_tester_pattern(PATTERN_BASE, resp_idx_q);
  assign activity     = req_fire || resp_fire;
  assign run_active   = (state_q == WRITE) || (state_q == READ) || (state_q == WAIT);
  assign wdog_expired = run_active && !activity && (wdog_q == WDOG_LAST);

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    resp_idx_d    = resp_idx_q;
    outstanding_d = outstanding_q;
    wdog_d        = wdog_q;
    done_d        = done_q;
    pass_d        = pass_q;
    timeout_d     = timeout_q;
    err_d         = err_q;
    first_d       = first_q;

    if (run_active) begin
      wdog_d = activity ? 32'd0 : wdog_q + 32'd1;

      if (resp_fire) begin
        resp_idx_d = resp_idx_q + 16'd1;
        if (resp_bad) begin
          if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
          if (first_q == 16'hFFFF) first_d = resp_idx_q;
        end
      end

      case ({req_fire && (state_q == READ), resp_fire})
        2'b10:   outstanding_d = outstanding_q + 4'd1;
        2'b01:   outstanding_d = outstanding_q - 4'd1;
        default: outstanding_d = outstanding_q;
      endcase

      if (req_fire) begin
        idx_d = idx_q + 16'd1;
        if (idx_q == LAST_IDX) begin
          if (state_q == WRITE) begin
            state_d = READ;
            idx_d   = 16'd0;
          end else begin
            state_d = WAIT;
          end
        end
      end

      if ((state_q == WAIT) && (outstanding_q == 4'd0)) begin
        state_d = DONE;
        done_d  = 1'b1;
        pass_d  = (err_q == 16'd0);
      end

      // The watchdog only fires on an idle cycle, so it never races a grant transition.
      if (wdog_expired) begin
        state_d   = DONE;
        done_d    = 1'b1;
        pass_d    = 1'b0;
        timeout_d = 1'b1;
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end else if (start) begin
      state_d       = WRITE;
      idx_d         = 16'd0;
      resp_idx_d    = 16'd0;
      outstanding_d = 4'd0;
      wdog_d        = 32'd0;
      done_d        = 1'b0;
      pass_d        = 1'b0;
      timeout_d     = 1'b0;
      err_d         = 16'd0;
      first_d       = 16'hFFFF;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= IDLE;
      idx_q         <= 16'd0;
      resp_idx_q    <= 16'd0;
      outstanding_q <= 4'd0;
      wdog_q        <= 32'd0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      timeout_q     <= 1'b0;
      err_q         <= 16'd0;
      first_q       <= 16'hFFFF;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      resp_idx_q    <= resp_idx_d;
      outstanding_q <= outstanding_d;
      wdog_q        <= wdog_d;
      done_q        <= done_d;
      pass_q        <= pass_d;
      timeout_q     <= timeout_d;
      err_q         <= err_d;
      first_q       <= first_d;
    end
  end

  assign busy          = run_active;
  assign done          = done_q;
  assign pass          = pass_q;
  assign timeout       = timeout_q;
  assign err_count     = err_q;
  assign first_err_idx = first_q;

endmodule

// File: tb/tb_ami_port_mem_tester.sv
// tb/tb_ami_port_mem_tester.sv - self-checking bench with a behavioural AMI memory model
module tb_ami_port_mem_tester;
  import ami_port_mem_tester_pkg::*;

  localparam int N = 8;

  logic        clk = 1'b0;
  logic        rst, start, grant, resp_grant;
  logic        busy, done, pass, timeout;
  logic [15:0] err_count, first_err_idx;
  MemReq       req;
  MemResp      resp;

  always #5 clk = ~clk;

  ami_port_mem_tester #(
    .NUM_LINES(N), .BASE_ADDR(64'd0), .STRIDE(64'd64), .PATTERN_BASE(32'hDEAD0000),
    .MAX_OUTSTANDING(2), .TIMEOUT_CYCLES(64)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .mem_req_out(req), .mem_req_grant_in(grant),
    .mem_resp_in(resp), .mem_resp_grant_out(resp_grant),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .err_count(err_count), .first_err_idx(first_err_idx)
  );

  int tests_run = 0;
  int tests_failed = 0;

  // AMI model state and observations
  typedef struct { int t; logic [511:0] d; } rsp_t;
  rsp_t         rq[$];
  logic [511:0] mem [0:N-1];
  int  cyc = 0, lat_min = 3, lat_max = 3, hold_left = 0, flip_bit = 0;
  bit  drop_resp = 0, rand_grant = 0, held_seen = 0, pend = 0;
  logic [7:0]   corrupt_mask = 8'd0;
  logic [63:0]  hold_addr = 64'd0, held_addr_obs;
  logic [511:0] held_data_obs;
  MemReq        pend_req;
  int  req_cnt = 0, seq_err = 0, stab_err = 0, bad_resp_grant = 0;
  int  outst = 0, max_out = 0, resp_cnt = 0, last_grant_cyc = 0;
  int  m_i, m_t;
  bit  m_wr;
  logic [31:0]  m_word;
  logic [511:0] m_d;

  always @(negedge clk) begin
    cyc++;
    if (hold_left > 0 && req.valid && req.isWrite && req.addr == hold_addr) begin
      grant = 1'b0;
      hold_left--;
      if (!held_seen) begin
        held_seen = 1; held_addr_obs = req.addr; held_data_obs = req.data;
      end
    end else begin
      grant = rand_grant ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
    resp.valid = !drop_resp && rq.size() > 0 && rq[0].t <= cyc;
    resp.data  = resp.valid ? rq[0].d : {16{$urandom}};
    #1;
    if (pend && rst && (req.valid !== 1'b1 || req !== pend_req)) stab_err++;
    pend     = rst && req.valid && !grant;
    pend_req = req;
    if (rst && resp_grant) begin
      if (!resp.valid) bad_resp_grant++;
      else begin
        void'(rq.pop_front());
        outst--;
        resp_cnt++;
      end
    end
    if (rst && req.valid && grant) begin
      m_wr   = req_cnt < N;
      m_i    = m_wr ? req_cnt : req_cnt - N;
      m_word = 32'hDEAD0000 + 32'(m_i);
      m_d    = m_wr ? {16{m_word}} : 512'd0;
      if (req_cnt >= 2 * N || req.isWrite !== m_wr || req.addr !== 64'(m_i) * 64 || req.data !== m_d)
        seq_err++;
      req_cnt++;
      last_grant_cyc = cyc;
      if (req.isWrite) mem[req.addr[8:6]] = req.data;
      else begin
        m_d = mem[req.addr[8:6]];
        if (corrupt_mask[req.addr[8:6]]) m_d[flip_bit] = ~m_d[flip_bit];
        m_t = cyc + int'($urandom_range(lat_min, lat_max));
        if (rq.size() > 0 && m_t < rq[$].t) m_t = rq[$].t;
        rq.push_back('{m_t, m_d});
        outst++;
        if (outst > max_out) max_out = outst;
      end
    end
  end

  task automatic model_clear();
    @(posedge clk);
    #1;
    rq.delete();
    req_cnt = 0; seq_err = 0; stab_err = 0; bad_resp_grant = 0; outst = 0; max_out = 0;
    resp_cnt = 0; pend = 0; held_seen = 0; hold_left = 0; corrupt_mask = 8'd0; flip_bit = 0;
    drop_resp = 0; rand_grant = 0; lat_min = 3; lat_max = 3;
  endtask

  task automatic start_run();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok, output int seen);
    ok = 0; seen = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk); #2;
      if (done) begin ok = 1; seen = cyc; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    tests_run++;
    if ({req.valid, resp_grant, busy, done, pass, timeout} !== 6'b0) begin
      tests_failed++;
      $display("FAIL reset_flags: got %b expected 000000", {req.valid, resp_grant, busy, done, pass, timeout});
    end
    tests_run++;
    if (err_count !== 16'd0 || first_err_idx !== 16'hFFFF) begin
      tests_failed++;
      $display("FAIL reset_stats: got err=%h first=%h expected 0000/ffff", err_count, first_err_idx);
    end
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_ideal();
    bit ok; int seen;
    model_clear();
    start_run();
    tests_run++;
    if (busy !== 1'b1) begin tests_failed++; $display("FAIL ideal_busy: got %b expected 1", busy); end
    wait_done(2000, ok, seen);
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL ideal_done: got no done expected done within budget"); end
    tests_run++;
    if ({done, pass, timeout, busy, req.valid} !== 5'b11000) begin
      tests_failed++; $display("FAIL ideal_status: got %b expected 11000", {done, pass, timeout, busy, req.valid});
    end
    tests_run++;
    if (err_count !== 16'd0 || first_err_idx !== 16'hFFFF) begin
      tests_failed++; $display("FAIL ideal_stats: got err=%h first=%h expected 0000/ffff", err_count, first_err_idx);
    end
    tests_run++;
    if (req_cnt !== 2 * N || seq_err !== 0 || resp_cnt !== N || bad_resp_grant !== 0 || stab_err !== 0) begin
      tests_failed++;
      $display("FAIL ideal_traffic: got req=%0d seqerr=%0d resp=%0d badgnt=%0d stab=%0d expected 16/0/8/0/0",
               req_cnt, seq_err, resp_cnt, bad_resp_grant, stab_err);
    end
  endtask

  task automatic test_hold();
    bit ok; int seen;
    model_clear();
    hold_addr = 64'hC0; hold_left = 5;
    start_run();
    wait_done(2000, ok, seen);
    tests_run++;
    if (!held_seen || held_addr_obs !== 64'hC0) begin
      tests_failed++; $display("FAIL hold_addr: got seen=%0d addr=%h expected c0", held_seen, held_addr_obs);
    end
    tests_run++;
    if (held_data_obs !== {16{32'hDEAD0003}}) begin
      tests_failed++; $display("FAIL hold_data: got %h expected pattern of dead0003", held_data_obs[31:0]);
    end
    tests_run++;
    if (stab_err !== 0 || hold_left !== 0 || seq_err !== 0) begin
      tests_failed++; $display("FAIL hold_stable: got stab=%0d left=%0d seq=%0d expected 0/0/0", stab_err, hold_left, seq_err);
    end
    tests_run++;
    if (!ok || {done, pass, timeout} !== 3'b110) begin
      tests_failed++; $display("FAIL hold_result: got ok=%0d %b expected 1 110", ok, {done, pass, timeout});
    end
  endtask

  task automatic test_outstanding();
    bit ok; int seen;
    model_clear();
    lat_min = 20; lat_max = 20;
    start_run();
    wait_done(3000, ok, seen);
    tests_run++;
    if (max_out !== 2) begin tests_failed++; $display("FAIL outstanding_max: got %0d expected 2", max_out); end
    tests_run++;
    if (!ok || {done, pass, timeout} !== 3'b110 || seq_err !== 0 || resp_cnt !== N) begin
      tests_failed++;
      $display("FAIL outstanding_result: got ok=%0d %b seq=%0d resp=%0d expected 1 110 0 8", ok, {done, pass, timeout}, seq_err, resp_cnt);
    end
  endtask

  task automatic test_corrupt();
    bit ok; int seen;
    model_clear();
    corrupt_mask = 8'b0010_0000; flip_bit = 0;
    start_run();
    wait_done(2000, ok, seen);
    tests_run++;
    if (!ok || err_count !== 16'd1 || first_err_idx !== 16'd5) begin
      tests_failed++; $display("FAIL corrupt_stats: got ok=%0d err=%0d first=%0d expected 1 1 5", ok, err_count, first_err_idx);
    end
    tests_run++;
    if ({done, pass, timeout} !== 3'b100) begin
      tests_failed++; $display("FAIL corrupt_status: got %b expected 100", {done, pass, timeout});
    end
  endtask

  task automatic test_random();
    bit ok; int seen; logic [15:0] exp_first; int exp_err;
    for (int r = 0; r < 4; r++) begin
      model_clear();
      rand_grant = 1; lat_min = 1; lat_max = 25;
      corrupt_mask = 8'($urandom);
      flip_bit = int'($urandom_range(0, 511));
      exp_err = $countones(corrupt_mask);
      exp_first = 16'hFFFF;
      for (int i = N - 1; i >= 0; i--) if (corrupt_mask[i]) exp_first = 16'(i);
      start_run();
      wait_done(4000, ok, seen);
      tests_run++;
      if (!ok || err_count !== 16'(exp_err) || first_err_idx !== exp_first || pass !== (exp_err == 0)) begin
        tests_failed++;
        $display("FAIL random_%0d: got ok=%0d err=%0d first=%h pass=%b expected err=%0d first=%h pass=%b",
                 r, ok, err_count, first_err_idx, pass, exp_err, exp_first, exp_err == 0);
      end
      tests_run++;
      if (seq_err !== 0 || stab_err !== 0 || resp_cnt !== N || max_out > 2) begin
        tests_failed++;
        $display("FAIL random_traffic_%0d: got seq=%0d stab=%0d resp=%0d maxout=%0d expected 0 0 8 <=2",
                 r, seq_err, stab_err, resp_cnt, max_out);
      end
    end
  endtask

  task automatic test_timeout();
    bit ok; int seen;
    model_clear();
    drop_resp = 1;
    start_run();
    wait_done(400, ok, seen);
    tests_run++;
    if (!ok || {done, pass, timeout, busy} !== 4'b1010) begin
      tests_failed++; $display("FAIL timeout_status: got ok=%0d %b expected 1 1010", ok, {done, pass, timeout, busy});
    end
    tests_run++;
    if (seen - last_grant_cyc < 64 || seen - last_grant_cyc > 66) begin
      tests_failed++; $display("FAIL timeout_delay: got %0d cycles expected about 64", seen - last_grant_cyc);
    end
    tests_run++;
    if (req_cnt !== N + 2) begin tests_failed++; $display("FAIL timeout_reqs: got %0d expected 10", req_cnt); end
  endtask

  task automatic test_reset_midrun();
    bit ok, in_read; int seen;
    model_clear();
    lat_min = 20; lat_max = 20;
    start_run();
    in_read = 0;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk); #2;
      if (req.valid && !req.isWrite) begin in_read = 1; break; end
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    tests_run++;
    if (!in_read || {req.valid, resp_grant, busy, done, pass, timeout} !== 6'b0 ||
        err_count !== 16'd0 || first_err_idx !== 16'hFFFF) begin
      tests_failed++;
      $display("FAIL midrun_reset: got read=%0d flags=%b err=%h first=%h expected 1 000000 0000 ffff",
               in_read, {req.valid, resp_grant, busy, done, pass, timeout}, err_count, first_err_idx);
    end
    model_clear();
    @(negedge clk); rst = 1'b1;
    start_run();
    ok = 0; seen = 0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      start = (k == 3 || k == 9 || k == 15);
      #2;
      if (done) begin ok = 1; seen = cyc; break; end
    end
    start = 1'b0;
    tests_run++;
    if (!ok || {done, pass, timeout} !== 3'b110 || req_cnt !== 2 * N || seq_err !== 0) begin
      tests_failed++;
      $display("FAIL midrun_rerun: got ok=%0d %b req=%0d seq=%0d expected 1 110 16 0", ok, {done, pass, timeout}, req_cnt, seq_err);
    end
  endtask

  initial begin
    test_reset();
    test_ideal();
    test_hold();
    test_outstanding();
    test_corrupt();
    test_random();
    test_timeout();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ami_port_mem_tester.md
Name: ami_port_mem_tester

Overview:
- Built-in memory self-test engine that drives one AMI application port: the mem_req_in / mem_resp_out pair of AmorphOSMem.
- On start it writes a deterministic pattern to NUM_LINES 64-byte lines, reads them back, compares every response and reports pass/fail with error statistics.
- It sits directly upstream of AmorphOSMem as an app and replaces the software-driven stimulus used in bring-up.

Parameters:
- NUM_LINES, 8: lines written then read; range 1..65535.
- BASE_ADDR, 0: byte address of line 0; must be 64-byte aligned.
- STRIDE, 64: byte distance between consecutive lines; a multiple of 64.
- PATTERN_BASE, 32'hDEAD0000: seed for the data pattern.
- MAX_OUTSTANDING, 4: maximum reads in flight; range 1..15.
- TIMEOUT_CYCLES, 1024: cycles without any grant or response before the run aborts.

Ports:
- clk  in  1  user clock.
- rst  in  1  synchronous reset, active-low.
- start  in  1  one-cycle pulse that begins a run; ignored while busy.
- mem_req_out  out  MemReq  request to the AMI port (valid, isWrite, addr, data).
- mem_req_grant_in  in  1  AMI accepted the request this cycle.
- mem_resp_in  in  MemResp  read response from the AMI port (valid, data).
- mem_resp_grant_out  out  1  tester consumes mem_resp_in this cycle.
- busy  out  1  a run is in progress.
- done  out  1  sticky; set at run end, cleared by the next accepted start.
- pass  out  1  valid when done=1; high only if err_count==0 and there was no timeout.
- timeout  out  1  sticky; the run aborted on the watchdog.
- err_count  out  16  number of mismatching read responses.
- first_err_idx  out  16  line index of the first mismatch; 16'hFFFF if none.

Behaviour:
- Reset (rst=0 at a clock edge):
  - State goes to IDLE. All counters clear.
  - mem_req_out.valid=0, mem_resp_grant_out=0, busy=0, done=0, pass=0, timeout=0, err_count=0, first_err_idx=16'hFFFF.
  - Reset mid-run abandons the run. The AMI is reset in the same domain, so there is no drain.
- Pattern: line i data = {16{PATTERN_BASE + i}}, 512 bits. Line i address = BASE_ADDR + i*STRIDE, computed in 64-bit width.
- Request handshake:
  - Once mem_req_out.valid is asserted, valid, addr and data stay stable until the cycle mem_req_grant_in=1.
  - The index advances on the grant edge, and the next request may be presented in the following cycle.
  - Back-to-back grants give one request per cycle.
- States:
  - IDLE: on start, clear the status outputs and move to WRITE; busy=1 from the next cycle.
  - WRITE: issue NUM_LINES writes (isWrite=1). Writes produce no response. After the last write grant, go to READ.
  - READ: issue NUM_LINES reads (isWrite=0, data=0).
    - Issue is suppressed (valid=0) while outstanding==MAX_OUTSTANDING.
    - outstanding increments on a read grant and decrements on a consumed response; both in the same cycle leave it unchanged.
    - After the last read grant, go to WAIT.
  - WAIT: stay until outstanding==0, then go to DONE.
  - DONE: busy=0, done=1, pass computed; return to IDLE in the same cycle. Status holds until the next start.
- Responses:
  - Responses arrive in request order per port.
  - mem_resp_grant_out = mem_resp_in.valid && state in {READ, WAIT} && outstanding>0. It is combinational and asserted the same cycle as valid.
  - Response k is compared against pattern k over all 512 bits.
  - On mismatch, err_count increments, saturating at 16'hFFFF. first_err_idx is written only while it is 16'hFFFF.
  - A response that is valid while outstanding==0 is not granted. This cannot occur legally.
- Watchdog:
  - The counter resets on any request grant or consumed response, and counts while in WRITE, READ or WAIT.
  - When it reaches TIMEOUT_CYCLES: set timeout=1, pass=0, drop valid and go to DONE.
- A start during busy is ignored. A start in the DONE cycle is ignored; a start in IDLE is accepted.

Decomposition:
- AMITypes package holds:
  - the tester state enum {IDLE, WRITE, READ, WAIT, DONE};
  - a function ami_tester_pattern(seed, idx) returning the 512-bit line;
  - line size constant AMI_LINE_BYTES=64.
- MemReq and MemResp are reused unchanged.
- No sub-module is required. The outstanding counter, the index counter and the watchdog are inline.

Test Plan:
- Default parameters, ideal AMI (grant always 1, read latency 3 cycles):
  - 8 writes to 0x000..0x1C0 with data DEAD0000..DEAD0007;
  - then 8 reads;
  - done=1, pass=1, err_count=0, first_err_idx=FFFF.
- Grant withheld for 5 cycles on write 3: request stays stable with addr 0xC0, data {16{DEAD0003}}; the run then passes.
- MAX_OUTSTANDING=2 with response latency 20: no more than 2 reads are ungranted-responded at any time; the run passes.
- Memory model corrupts line 5 bit 0: err_count=1, first_err_idx=5, pass=0.
- Responses never return and TIMEOUT_CYCLES=64: timeout=1, pass=0, done=1 and busy=0 about 64 cycles after the last grant.
- rst=0 asserted during READ, then a new start: status is cleared and the second run passes; start pulses during busy have no effect.
